// File: rtl/uart_tx_buffer_pkg.sv
// rtl/uart_tx_buffer_pkg.sv - shared uart package: defaults and launch FSM encoding
package uart_tx_buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DEFAULT_ADDR_BITS     = 4;
  localparam int DEFAULT_START_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_WAIT_DONE  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/uart_tx_buffer_mem.sv
// rtl/uart_tx_buffer_mem.sv - simple dual-port storage, synchronous write, asynchronous head read
module uart_tx_buffer_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_buffer.sv
// rtl/uart_tx_buffer.sv - MMIO byte FIFO feeding a UART core through a launch/busy handshake
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  flush,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_BITS:0]    count,
  output logic                  overflow,
  output logic                  idle,
  output logic                  tx_ena,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy
);

  localparam logic [ADDR_BITS:0] DEPTH = {1'b1, {ADDR_BITS{1'b0}}};
  localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  tx_state_t             state, state_next;
  logic [TW-1:0]         timer, timer_next;
  logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  accept, pop;

  assign full   = (count == DEPTH);
  assign empty  = (count == '0);
  assign idle   = empty && (state == ST_IDLE);
  // full is the registered state, so a same-cycle pop never makes room for a write
  assign accept = wr_en && !full && !flush;

  uart_tx_buffer_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (accept),
    .waddr(wr_ptr),
    .wdata(wr_data),
    .raddr(rd_ptr),
    .rdata(head)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !tx_busy && !flush) begin
          pop        = 1'b1;
          state_next = ST_WAIT_START;
          timer_next = '0;
        end
      end
      ST_WAIT_START: begin
        // a core that never acknowledges still counts the byte as sent
        if (tx_busy)                              state_next = ST_WAIT_DONE;
        else if (timer == TW'(START_TIMEOUT - 1)) state_next = ST_IDLE;
        else                                      timer_next = timer + TW'(1);
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop)    rd_ptr <= rd_ptr + ADDR_BITS'(1);
      if (wr_en && full) overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_ena  <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_ena <= pop;
      if (pop) tx_data <= head;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb/tb_uart_tx_buffer.sv - directed self-checking bench for uart_tx_buffer
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       full, empty, overflow, idle, tx_ena;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_busy;

  logic       busy_force;
  logic       model_en;
  int         model_len;
  logic       model_busy = 1'b0;
  int         busy_cnt = 0;

  logic [7:0] launched [$];
  int         ena_total = 0;
  int         dbl_ena = 0;
  logic       prev_ena = 1'b0;

  int checks = 0;
  int errors = 0;

  assign tx_busy = busy_force | model_busy;

  uart_tx_buffer dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .overflow(overflow),
    .idle    (idle),
    .tx_ena  (tx_ena),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
  );

  always #10 clk = ~clk;

  // UART core model: busy rises half a cycle after a launch and holds model_len cycles
  always @(negedge clk) begin
    if (!model_en) begin
      model_busy = 1'b0;
      busy_cnt   = 0;
    end else begin
      if (tx_ena) busy_cnt = model_len;
      if (busy_cnt > 0) begin
        model_busy = 1'b1;
        busy_cnt   = busy_cnt - 1;
      end else begin
        model_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (resetn && tx_ena) begin
      launched.push_back(tx_data);
      ena_total = ena_total + 1;
      if (prev_ena) dbl_ena = dbl_ena + 1;
    end
    prev_ena = resetn && tx_ena;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic wait_drain(input int target, input int budget, input string tag);
    int n = 0;
    while (!(launched.size() >= target && idle && !tx_busy) && n < budget) begin
      cycle();
      n = n + 1;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_tx_ena"},   32'(tx_ena),   32'd0);
    check({pfx, "_tx_data"},  32'(tx_data),  32'd0);
    check({pfx, "_full"},     32'(full),     32'd0);
    check({pfx, "_empty"},    32'(empty),    32'd1);
    check({pfx, "_count"},    32'(count),    32'd0);
    check({pfx, "_overflow"}, 32'(overflow), 32'd0);
    check({pfx, "_idle"},     32'(idle),     32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int mism;
    int n;

    resetn     = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    flush      = 1'b0;
    busy_force = 1'b0;
    model_en   = 1'b0;
    model_len  = 10;
    #1;
    check_reset_values("reset");
    repeat (3) cycle();
    resetn = 1'b1;
    cycle();

    // single byte, latency and return to idle
    model_en  = 1'b1;
    model_len = 10;
    base      = launched.size();
    wr(8'h55);
    check("single_no_early_ena", 32'(tx_ena), 32'd0);
    check("single_count_after_wr", 32'(count), 32'd1);
    cycle();
    check("single_ena", 32'(tx_ena), 32'd1);
    check("single_data", 32'(tx_data), 32'h55);
    check("single_count_after_pop", 32'(count), 32'd0);
    cycle();
    check("single_ena_one_cycle", 32'(tx_ena), 32'd0);
    repeat (11) cycle();
    check("single_idle", 32'(idle), 32'd1);
    check("single_launch_count", launched.size() - base, 32'd1);

    // fill and overflow while the core is busy
    model_en   = 1'b0;
    busy_force = 1'b1;
    cycle();
    base  = launched.size();
    wr_en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_data = 8'(i);
      cycle();
    end
    wr_en = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    check("fill_overflow", 32'(overflow), 32'd1);
    check("fill_no_launch", launched.size() - base, 32'd0);
    model_en   = 1'b1;
    model_len  = 3;
    busy_force = 1'b0;
    wait_drain(base + 16, 400, "fill_drain_timeout");
    repeat (20) cycle();
    check("fill_launch_count", launched.size() - base, 32'd16);
    mism = 0;
    for (int i = 0; i < 16; i++)
      if (base + i >= launched.size() || launched[base + i] != 8'(i)) mism = mism + 1;
    check("fill_order_mismatches", 32'(mism), 32'd0);
    check("fill_overflow_sticky", 32'(overflow), 32'd1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_clears_overflow", 32'(overflow), 32'd0);

    // wrap-around stream of 40 bytes
    base = launched.size();
    n    = ena_total;
    for (int i = 0; i < 40; i++) begin
      int guard = 0;
      while (full && guard < 100) begin
        cycle();
        guard = guard + 1;
      end
      wr(8'(i * 7 + 3));
    end
    wait_drain(base + 40, 600, "wrap_drain_timeout");
    check("wrap_launch_count", launched.size() - base, 32'd40);
    check("wrap_ena_count", 32'(ena_total - n), 32'd40);
    mism = 0;
    for (int i = 0; i < 40; i++)
      if (base + i >= launched.size() || launched[base + i] != 8'(i * 7 + 3)) mism = mism + 1;
    check("wrap_order_mismatches", 32'(mism), 32'd0);
    check("wrap_count_zero", 32'(count), 32'd0);
    check("wrap_no_overflow", 32'(overflow), 32'd0);

    // start timeout: core never raises busy
    model_en = 1'b0;
    cycle();
    wr(8'hA1);
    wr(8'hA2);
    check("timeout_first_ena", 32'(tx_ena), 32'd1);
    check("timeout_first_data", 32'(tx_data), 32'hA1);
    n = 0;
    do begin
      cycle();
      n = n + 1;
    end while (!tx_ena && n < 40);
    check("timeout_relaunch_gap", 32'(n), 32'd16);
    check("timeout_second_data", 32'(tx_data), 32'hA2);
    repeat (16) cycle();
    check("timeout_idle", 32'(idle), 32'd1);

    // flush with one byte in flight and five queued
    model_en  = 1'b1;
    model_len = 10;
    cycle();
    base = launched.size();
    for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i));
    check("flush_queued", 32'(count), 32'd5);
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    cycle();
    flush = 1'b0;
    wr_en = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_overflow", 32'(overflow), 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    repeat (25) cycle();
    check("flush_inflight_only", launched.size() - base, 32'd1);
    check("flush_inflight_data", 32'(launched[base]), 32'hC0);
    check("flush_idle", 32'(idle), 32'd1);

    // reset during WAIT_DONE with three bytes queued
    base = launched.size();
    for (int i = 0; i < 4; i++) wr(8'hD0 + 8'(i));
    repeat (2) cycle();
    check("rst_pre_count", 32'(count), 32'd3);
    check("rst_pre_busy", 32'(tx_busy), 32'd1);
    #3;
    resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    cycle();
    resetn = 1'b1;
    base = launched.size();
    repeat (30) cycle();
    check("rst_no_launch", launched.size() - base, 32'd0);
    check("rst_idle", 32'(idle), 32'd1);

    check("single_cycle_ena", 32'(dbl_ena), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
